// File: rtl/layer_act_forwarder.sv
// Transmit side of the layer write interface: buffers producer results in a FIFO,
// replays them as activation writes and pulses compute once per full feature map.
module layer_act_forwarder #(
    parameter int DATA_SIZE  = 64,
    parameter int IDX_W      = 16,
    parameter int OUT_CH     = 16,
    parameter int OUT_DIM    = 26,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_SIZE-1:0]     in_data,
    input  logic [2:0][IDX_W-1:0]    in_index,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     dst_ready,
    output logic                     want_write_act,
    output logic [DATA_SIZE-1:0]     write_data,
    output logic [IDX_W-1:0]         in_index3,
    output logic [IDX_W-1:0]         in_index2,
    output logic [IDX_W-1:0]         in_index1,
    output logic [IDX_W-1:0]         in_index0,
    output logic                     compute,
    output logic                     frame_done,
    input  logic                     restart,
    output logic                     err_index,
    output logic                     err_overflow
);

    localparam int TOTAL   = OUT_CH * OUT_DIM * OUT_DIM;
    localparam int CNT_W   = $clog2(TOTAL + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = DATA_SIZE + 3 * IDX_W;

    localparam logic [IDX_W-1:0] CH_LIM    = IDX_W'(OUT_CH);
    localparam logic [IDX_W-1:0] DIM_LIM   = IDX_W'(OUT_DIM);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TOTAL - 1);
    localparam logic [PTR_W:0]   DEPTH_OCC = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_STREAM = 2'd0,
        ST_FIRE   = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   count_r;
    logic [ENTRY_W-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W:0]     occ_r;

    logic               in_range_s;
    logic               push_s;
    logic               pop_s;
    logic               frame_last_s;
    logic               stream_nx_s;
    logic [PTR_W-1:0]   rd_ptr_nx_s;
    logic [PTR_W:0]     occ_nx_s;
    logic [ENTRY_W-1:0] in_entry_s;
    logic [ENTRY_W-1:0] head_nx_s;

    assign in_index3 = {IDX_W{1'b0}};

    // Handshake decode, next FIFO occupancy and the entry to present after this edge
    always_comb begin
        in_range_s   = (in_index[2] < CH_LIM) && (in_index[1] < DIM_LIM) &&
                       (in_index[0] < DIM_LIM);
        push_s       = in_valid && in_ready && in_range_s;
        pop_s        = want_write_act && dst_ready;
        frame_last_s = pop_s && (state_r == ST_STREAM) && (count_r == LAST_CNT);
        stream_nx_s  = ((state_r == ST_STREAM) && !frame_last_s) ||
                       ((state_r == ST_DONE) && restart);
        rd_ptr_nx_s  = rd_ptr_r + PTR_W'(pop_s);
        occ_nx_s     = occ_r + (PTR_W + 1)'(push_s) - (PTR_W + 1)'(pop_s);
        in_entry_s   = {in_data, in_index[2], in_index[1], in_index[0]};
        // An entry written into an empty FIFO becomes the head in the same edge
        if (push_s && (wr_ptr_r == rd_ptr_nx_s)) begin
            head_nx_s = in_entry_s;
        end else begin
            head_nx_s = mem_r[rd_ptr_nx_s];
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (rst_n && push_s) begin
            mem_r[wr_ptr_r] <= in_entry_s;
        end
    end

    // Pointers, occupancy and the registered write port
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r       <= {PTR_W{1'b0}};
            rd_ptr_r       <= {PTR_W{1'b0}};
            occ_r          <= {(PTR_W + 1){1'b0}};
            in_ready       <= 1'b0;
            want_write_act <= 1'b0;
            write_data     <= {DATA_SIZE{1'b0}};
            in_index2      <= {IDX_W{1'b0}};
            in_index1      <= {IDX_W{1'b0}};
            in_index0      <= {IDX_W{1'b0}};
        end else begin
            wr_ptr_r       <= wr_ptr_r + PTR_W'(push_s);
            rd_ptr_r       <= rd_ptr_nx_s;
            occ_r          <= occ_nx_s;
            in_ready       <= stream_nx_s && (occ_nx_s < DEPTH_OCC);
            want_write_act <= stream_nx_s && (occ_nx_s != {(PTR_W + 1){1'b0}});
            if (occ_nx_s != {(PTR_W + 1){1'b0}}) begin
                {write_data, in_index2, in_index1, in_index0} <= head_nx_s;
            end
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_index    <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (in_valid && in_ready && !in_range_s) begin
                err_index <= 1'b1;
            end
            if (in_valid && !in_ready) begin
                err_overflow <= 1'b1;
            end
        end
    end

    // Frame sequencing: count transfers, fire compute once per map, wait for restart
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_STREAM;
            count_r    <= {CNT_W{1'b0}};
            compute    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state_r)
                ST_STREAM: begin
                    frame_done <= 1'b0;
                    if (frame_last_s) begin
                        state_r <= ST_FIRE;
                        compute <= 1'b1;
                        count_r <= count_r + CNT_W'(1);
                    end else begin
                        compute <= 1'b0;
                        if (pop_s) begin
                            count_r <= count_r + CNT_W'(1);
                        end
                    end
                end
                ST_FIRE: begin
                    compute    <= 1'b0;
                    frame_done <= 1'b1;
                    state_r    <= ST_DONE;
                end
                ST_DONE: begin
                    compute <= 1'b0;
                    if (restart) begin
                        state_r    <= ST_STREAM;
                        count_r    <= {CNT_W{1'b0}};
                        frame_done <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_STREAM;
                    count_r    <= {CNT_W{1'b0}};
                    compute    <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_act_forwarder.sv
// Bench for layer_act_forwarder: a full-size instance (A) and a 2x2x2 frame
// instance (B), each checked against a queue-based reference model.
module tb_layer_act_forwarder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] d;
        logic [15:0] c;
        logic [15:0] r;
        logic [15:0] k;
    } ent_t;

    logic              a_rst_n, a_in_valid, a_in_ready, a_dst_ready, a_want;
    logic              a_compute, a_frame_done, a_restart, a_err_index, a_err_overflow;
    logic [63:0]       a_in_data, a_write_data;
    logic [2:0][15:0]  a_in_index;
    logic [15:0]       a_idx3, a_idx2, a_idx1, a_idx0;

    logic              b_rst_n, b_in_valid, b_in_ready, b_dst_ready, b_want;
    logic              b_compute, b_frame_done, b_restart, b_err_index, b_err_overflow;
    logic [63:0]       b_in_data, b_write_data;
    logic [2:0][15:0]  b_in_index;
    logic [15:0]       b_idx3, b_idx2, b_idx1, b_idx0;

    layer_act_forwarder dut_a (
        .clk(clk), .rst_n(a_rst_n), .in_data(a_in_data), .in_index(a_in_index),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .dst_ready(a_dst_ready),
        .want_write_act(a_want), .write_data(a_write_data),
        .in_index3(a_idx3), .in_index2(a_idx2), .in_index1(a_idx1), .in_index0(a_idx0),
        .compute(a_compute), .frame_done(a_frame_done), .restart(a_restart),
        .err_index(a_err_index), .err_overflow(a_err_overflow)
    );

    layer_act_forwarder #(.OUT_CH(2), .OUT_DIM(2)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .in_data(b_in_data), .in_index(b_in_index),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .dst_ready(b_dst_ready),
        .want_write_act(b_want), .write_data(b_write_data),
        .in_index3(b_idx3), .in_index2(b_idx2), .in_index1(b_idx1), .in_index0(b_idx0),
        .compute(b_compute), .frame_done(b_frame_done), .restart(b_restart),
        .err_index(b_err_index), .err_overflow(b_err_overflow)
    );

    ent_t qa[$];
    ent_t qb[$];
    bit   ma_eidx, ma_eovf, mb_eidx, mb_eovf;
    int   mb_phase;   // 0 streaming, 1 compute pulse, 2 frame done
    int   mb_cnt;
    int   cmp_cnt = 0;
    int   fail_cnt = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ent_t rnd_ent(input int maxc, input int maxd);
        ent_t e;
        e.d = {$urandom, $urandom};
        e.c = 16'($urandom_range(maxc, 0));
        e.r = 16'($urandom_range(maxd, 0));
        e.k = 16'($urandom_range(maxd, 0));
        return e;
    endfunction

    // Drive one cycle on A and advance its model (16 channels, 26x26 map)
    task automatic a_step(input bit v, input ent_t e, input bit dr);
        bit rdy, inr, acc, xfer;
        a_in_valid = v; a_in_data = e.d; a_dst_ready = dr;
        a_in_index[2] = e.c; a_in_index[1] = e.r; a_in_index[0] = e.k;
        rdy  = qa.size() < 8;
        inr  = (e.c < 16) && (e.r < 26) && (e.k < 26);
        acc  = v && rdy && inr;
        if (v && rdy && !inr) ma_eidx = 1'b1;
        if (v && !rdy) ma_eovf = 1'b1;
        xfer = (qa.size() > 0) && dr;
        tick();
        if (xfer) void'(qa.pop_front());
        if (acc) qa.push_back(e);
    endtask

    // Drive one cycle on B and advance its model (8 entries per frame)
    task automatic b_step(input bit v, input ent_t e, input bit dr, input bit rs);
        bit rdy, inr, acc, xfer;
        b_in_valid = v; b_in_data = e.d; b_dst_ready = dr; b_restart = rs;
        b_in_index[2] = e.c; b_in_index[1] = e.r; b_in_index[0] = e.k;
        rdy  = (mb_phase == 0) && (qb.size() < 8);
        inr  = (e.c < 2) && (e.r < 2) && (e.k < 2);
        acc  = v && rdy && inr;
        if (v && rdy && !inr) mb_eidx = 1'b1;
        if (v && !rdy) mb_eovf = 1'b1;
        xfer = (mb_phase == 0) && (qb.size() > 0) && dr;
        tick();
        if (xfer) begin
            void'(qb.pop_front());
            mb_cnt++;
            if (mb_cnt == 8) mb_phase = 1;
        end else if (mb_phase == 1) begin
            mb_phase = 2;
        end else if (mb_phase == 2 && rs) begin
            mb_phase = 0;
            mb_cnt = 0;
        end
        if (acc) qb.push_back(e);
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_in_valid = 1'b0; a_dst_ready = 1'b0; a_restart = 1'b0;
        b_in_valid = 1'b0; b_dst_ready = 1'b0; b_restart = 1'b0;
        a_in_data = 64'd0; a_in_index = 48'd0; b_in_data = 64'd0; b_in_index = 48'd0;
        repeat (2) tick();
        cmp_cnt++;
        if ({a_want, a_in_ready, a_compute, a_frame_done, a_err_index, a_err_overflow} !== 6'b0) begin
            fail_cnt++;
            $display("FAIL reset_ctrl_a: got %b expected 000000",
                {a_want, a_in_ready, a_compute, a_frame_done, a_err_index, a_err_overflow});
        end
        cmp_cnt++;
        if ({a_write_data, a_idx3, a_idx2, a_idx1, a_idx0} !== 128'd0) begin
            fail_cnt++;
            $display("FAIL reset_data_a: got %h expected 0", {a_write_data, a_idx3, a_idx2, a_idx1, a_idx0});
        end
        cmp_cnt++;
        if ({b_want, b_in_ready, b_compute, b_frame_done} !== 4'b0) begin
            fail_cnt++;
            $display("FAIL reset_ctrl_b: got %b expected 0000", {b_want, b_in_ready, b_compute, b_frame_done});
        end
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        qa.delete(); qb.delete();
        ma_eidx = 0; ma_eovf = 0; mb_eidx = 0; mb_eovf = 0; mb_phase = 0; mb_cnt = 0;
        tick();
        cmp_cnt++;
        if ({a_in_ready, b_in_ready, a_want} !== 3'b110) begin
            fail_cnt++;
            $display("FAIL ready_after_reset: got %b expected 110", {a_in_ready, b_in_ready, a_want});
        end
    endtask

    task automatic test_single_write();
        ent_t e;
        e = '{d: 64'h3FF0000000000000, c: 16'd3, r: 16'd5, k: 16'd7};
        a_step(1'b1, e, 1'b1);
        cmp_cnt++;
        if (a_want !== 1'b1) begin
            fail_cnt++;
            $display("FAIL single_want: got %b expected 1", a_want);
        end
        cmp_cnt++;
        if ({a_write_data, a_idx3, a_idx2, a_idx1, a_idx0} !==
            {64'h3FF0000000000000, 16'd0, 16'd3, 16'd5, 16'd7}) begin
            fail_cnt++;
            $display("FAIL single_data: got %h/%0d/%0d/%0d/%0d expected 3ff0000000000000/0/3/5/7",
                a_write_data, a_idx3, a_idx2, a_idx1, a_idx0);
        end
        a_step(1'b0, e, 1'b1);
        cmp_cnt++;
        if (a_want !== 1'b0) begin
            fail_cnt++;
            $display("FAIL single_one_cycle: got %b expected 0", a_want);
        end
    endtask

    task automatic test_backpressure();
        ent_t e, first;
        for (int i = 0; i < 12; i++) begin
            e = rnd_ent(15, 25);
            if (i == 0) first = e;
            a_step(1'b1, e, 1'b0);
            cmp_cnt++;
            if ({a_want, a_write_data, a_idx2, a_idx1, a_idx0} !== {1'b1, first}) begin
                fail_cnt++;
                $display("FAIL bp_stable[%0d]: got %b/%h expected 1/%h", i, a_want,
                    {a_write_data, a_idx2, a_idx1, a_idx0}, first);
            end
        end
        cmp_cnt++;
        if ({a_in_ready, a_err_overflow, qa.size() == 8} !== 3'b011) begin
            fail_cnt++;
            $display("FAIL bp_full: got ready=%b ovf=%b expected ready=0 ovf=1", a_in_ready, a_err_overflow);
        end
        for (int i = 0; i < 8; i++) begin
            cmp_cnt++;
            if ({a_want, a_write_data, a_idx2, a_idx1, a_idx0} !== {1'b1, qa[0]}) begin
                fail_cnt++;
                $display("FAIL bp_drain[%0d]: got %b/%h expected 1/%h", i, a_want,
                    {a_write_data, a_idx2, a_idx1, a_idx0}, qa[0]);
            end
            a_step(1'b0, '0, 1'b1);
        end
        cmp_cnt++;
        if ({a_want, a_in_ready} !== 2'b01) begin
            fail_cnt++;
            $display("FAIL bp_empty: got %b expected 01", {a_want, a_in_ready});
        end
    endtask

    task automatic test_index_range();
        ent_t e;
        e = rnd_ent(15, 25); e.r = 16'd26;
        a_step(1'b1, e, 1'b1);
        cmp_cnt++;
        if ({a_want, a_err_index} !== 2'b01) begin
            fail_cnt++;
            $display("FAIL range_row26: got want=%b err=%b expected 0 1", a_want, a_err_index);
        end
        e = rnd_ent(15, 25); e.c = 16'd16;
        a_step(1'b1, e, 1'b1);
        e = rnd_ent(15, 25); e.k = 16'd26;
        a_step(1'b1, e, 1'b1);
        cmp_cnt++;
        if (a_want !== 1'b0) begin
            fail_cnt++;
            $display("FAIL range_ch_col: got want=%b expected 0", a_want);
        end
        e = rnd_ent(15, 25); e.c = 16'd15; e.r = 16'd25; e.k = 16'd25;
        a_step(1'b1, e, 1'b1);
        cmp_cnt++;
        if ({a_want, a_write_data, a_idx2, a_idx1, a_idx0} !== {1'b1, e}) begin
            fail_cnt++;
            $display("FAIL range_max_ok: got %b/%h expected 1/%h", a_want,
                {a_write_data, a_idx2, a_idx1, a_idx0}, e);
        end
        a_step(1'b0, '0, 1'b1);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) a_step(1'b1, rnd_ent(15, 25), 1'b0);
        cmp_cnt++;
        if (a_want !== 1'b1) begin
            fail_cnt++;
            $display("FAIL mid_prefill: got %b expected 1", a_want);
        end
        a_rst_n = 1'b0; a_in_valid = 1'b0;
        tick();
        a_rst_n = 1'b1;
        qa.delete(); ma_eidx = 0; ma_eovf = 0;
        cmp_cnt++;
        if ({a_want, a_in_ready, a_err_index, a_err_overflow} !== 4'b0) begin
            fail_cnt++;
            $display("FAIL mid_reset_state: got %b expected 0000",
                {a_want, a_in_ready, a_err_index, a_err_overflow});
        end
        for (int i = 0; i < 10; i++) begin
            a_step(1'b0, '0, 1'b1);
            cmp_cnt++;
            if (a_want !== 1'b0) begin
                fail_cnt++;
                $display("FAIL mid_no_write[%0d]: got %b expected 0", i, a_want);
            end
        end
    endtask

    task automatic test_random_stream();
        ent_t e;
        bit v, dr;
        for (int i = 0; i < 400; i++) begin
            v  = $urandom_range(9, 0) < 7;
            dr = $urandom_range(3, 0) != 0;
            e  = rnd_ent(17, 27);
            a_step(v, e, dr);
            cmp_cnt++;
            if ({a_want, a_in_ready, a_err_index, a_err_overflow} !==
                {qa.size() > 0, qa.size() < 8, ma_eidx, ma_eovf}) begin
                fail_cnt++;
                $display("FAIL rand_ctrl[%0d]: got %b expected %b", i,
                    {a_want, a_in_ready, a_err_index, a_err_overflow},
                    {qa.size() > 0, qa.size() < 8, ma_eidx, ma_eovf});
            end
            if (qa.size() > 0) begin
                cmp_cnt++;
                if ({a_write_data, a_idx3, a_idx2, a_idx1, a_idx0} !== {qa[0].d, 16'd0, qa[0].c, qa[0].r, qa[0].k}) begin
                    fail_cnt++;
                    $display("FAIL rand_data[%0d]: got %h expected %h", i,
                        {a_write_data, a_idx2, a_idx1, a_idx0}, qa[0]);
                end
            end
        end
    endtask

    task automatic test_frame();
        ent_t e;
        int   pulses = 0;
        // restart while streaming must be ignored
        b_step(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 40; i++) begin
            e = rnd_ent(1, 1);
            if (i < 9) begin
                e.c = 16'((i < 4 ? i : i - 1) >> 2);
                e.r = 16'(((i < 4 ? i : i - 1) >> 1) & 1);
                e.k = 16'((i < 4 ? i : i - 1) & 1);
                if (i == 4) e.c = 16'd2;
            end
            b_step(i < 9 || (i >= 20 && i < 29), e, 1'b1, i == 15);
            if (b_compute === 1'b1) pulses++;
            cmp_cnt++;
            if ({b_want, b_in_ready, b_compute, b_frame_done} !==
                {mb_phase == 0 && qb.size() > 0, mb_phase == 0 && qb.size() < 8, mb_phase == 1, mb_phase == 2}) begin
                fail_cnt++;
                $display("FAIL frame_ctrl[%0d]: got %b expected %b", i,
                    {b_want, b_in_ready, b_compute, b_frame_done},
                    {mb_phase == 0 && qb.size() > 0, mb_phase == 0 && qb.size() < 8, mb_phase == 1, mb_phase == 2});
            end
            if (mb_phase == 0 && qb.size() > 0) begin
                cmp_cnt++;
                if ({b_write_data, b_idx2, b_idx1, b_idx0} !== qb[0]) begin
                    fail_cnt++;
                    $display("FAIL frame_data[%0d]: got %h expected %h", i,
                        {b_write_data, b_idx2, b_idx1, b_idx0}, qb[0]);
                end
            end
        end
        // two frames complete: the first after an ignored index, the second leaves one entry
        cmp_cnt++;
        if ({pulses, b_err_index} !== {32'd2, 1'b1}) begin
            fail_cnt++;
            $display("FAIL frame_pulses: got %0d err=%b expected 2 err=1", pulses, b_err_index);
        end
    endtask

    task automatic test_random_frames();
        ent_t e;
        for (int i = 0; i < 500; i++) begin
            e = rnd_ent(2, 2);
            b_step($urandom_range(2, 0) != 0, e, $urandom_range(3, 0) != 0, $urandom_range(3, 0) == 0);
            cmp_cnt++;
            if ({b_want, b_in_ready, b_compute, b_frame_done, b_err_index, b_err_overflow} !==
                {mb_phase == 0 && qb.size() > 0, mb_phase == 0 && qb.size() < 8,
                 mb_phase == 1, mb_phase == 2, mb_eidx, mb_eovf}) begin
                fail_cnt++;
                $display("FAIL rframe_ctrl[%0d]: got %b expected %b", i,
                    {b_want, b_in_ready, b_compute, b_frame_done, b_err_index, b_err_overflow},
                    {mb_phase == 0 && qb.size() > 0, mb_phase == 0 && qb.size() < 8,
                     mb_phase == 1, mb_phase == 2, mb_eidx, mb_eovf});
            end
            if (mb_phase == 0 && qb.size() > 0) begin
                cmp_cnt++;
                if ({b_write_data, b_idx3, b_idx2, b_idx1, b_idx0} !== {qb[0].d, 16'd0, qb[0].c, qb[0].r, qb[0].k}) begin
                    fail_cnt++;
                    $display("FAIL rframe_data[%0d]: got %h expected %h", i,
                        {b_write_data, b_idx2, b_idx1, b_idx0}, qb[0]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_backpressure();
        test_index_range();
        test_reset_mid();
        test_random_stream();
        test_frame();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
